// File: rtl/shift_iter_unit.sv
// Iterative 32-bit shifter (SLL / SRA): one power-of-two stage per clock, MSB stage first.
// Start/ready handshake: accepts in IDLE or DONE, pulses data_resultRDY for one cycle.
module shift_iter_unit #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ctrl_start,
   input  logic               ctrl_shiftop,
   input  logic [SHAMT_W-1:0] ctrl_shiftamt,
   input  logic [DATA_W-1:0]  data_operandA,
   output logic [DATA_W-1:0]  data_result,
   output logic               data_resultRDY,
   output logic               busy
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q;
   logic [DATA_W-1:0]  opr_q;
   logic [SHAMT_W-1:0] amt_q;
   logic [SHAMT_W-1:0] stage_q;
   logic               op_q;

   logic [SHAMT_W-1:0] stage_dist;
   logic [DATA_W-1:0]  stage_out;

   // Current stage shifts by 2^stage_q when the matching amount bit is set.
   always_comb begin
      stage_dist = {{(SHAMT_W-1){1'b0}}, 1'b1} << stage_q;
      stage_out  = opr_q;
      if (amt_q[stage_q]) begin
         if (op_q) begin
            stage_out = $unsigned($signed(opr_q) >>> stage_dist);
         end else begin
            stage_out = opr_q << stage_dist;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= StIdle;
         opr_q          <= '0;
         amt_q          <= '0;
         stage_q        <= '0;
         op_q           <= 1'b0;
         data_result    <= '0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (ctrl_start) begin
                  opr_q   <= data_operandA;
                  amt_q   <= ctrl_shiftamt;
                  op_q    <= ctrl_shiftop;
                  stage_q <= SHAMT_W'(SHAMT_W - 1);
                  state_q <= StShift;
                  busy    <= 1'b1;
               end else begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end
            end
            StShift: begin
               opr_q   <= stage_out;
               stage_q <= stage_q - 1'b1;
               if (stage_q == '0) begin
                  state_q        <= StDone;
                  busy           <= 1'b0;
                  data_resultRDY <= 1'b1;
                  data_result    <= stage_out;
               end
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_iter_unit.sv
// Directed bench for shift_iter_unit: latency, handshake, boundaries and a full shamt sweep.
module tb_shift_iter_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_start;
   logic        ctrl_shiftop;
   logic [4:0]  ctrl_shiftamt;
   logic [31:0] data_operandA;
   logic [31:0] data_result;
   logic        data_resultRDY;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   shift_iter_unit #(
      .DATA_W  (32),
      .SHAMT_W (5)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_start     (ctrl_start),
      .ctrl_shiftop   (ctrl_shiftop),
      .ctrl_shiftamt  (ctrl_shiftamt),
      .data_operandA  (data_operandA),
      .data_result    (data_result),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic op, input logic [4:0] amt,
                                             input logic [31:0] a);
      if (op) return $unsigned($signed(a) >>> amt);
      return a << amt;
   endfunction

   // Accept one op, scramble inputs afterwards, check busy/RDY timing, result and hold.
   task automatic do_op(input string tag, input logic op, input logic [4:0] amt,
                        input logic [31:0] a, input logic [31:0] exp);
      ctrl_start    = 1'b1;
      ctrl_shiftop  = op;
      ctrl_shiftamt = amt;
      data_operandA = a;
      step();
      ctrl_start    = 1'b0;
      ctrl_shiftop  = ~op;
      ctrl_shiftamt = ~amt;
      data_operandA = ~a;
      for (int c = 1; c <= 5; c++) begin
         check_eq({tag, "_busy"}, 32'(busy), 32'd1);
         check_eq({tag, "_rdy_early"}, 32'(data_resultRDY), 32'd0);
         step();
      end
      check_eq({tag, "_rdy"}, 32'(data_resultRDY), 32'd1);
      check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
      check_eq({tag, "_result"}, data_result, exp);
      step();
      check_eq({tag, "_rdy_pulse"}, 32'(data_resultRDY), 32'd0);
      check_eq({tag, "_hold"}, data_result, exp);
   endtask

   initial begin
      reset         = 1'b1;
      ctrl_start    = 1'b0;
      ctrl_shiftop  = 1'b0;
      ctrl_shiftamt = '0;
      data_operandA = '0;
      step();
      step();
      check_eq("rst_result", data_result, 32'h0);
      check_eq("rst_rdy", 32'(data_resultRDY), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      step();

      do_op("sll31", 1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000);
      do_op("sra16n", 1'b1, 5'd16, 32'h8000_0000, 32'hFFFF_8000);
      do_op("sra16p", 1'b1, 5'd16, 32'h7FFF_0000, 32'h0000_7FFF);
      do_op("sll16", 1'b0, 5'd16, 32'h1234_5678, 32'h5678_0000);
      do_op("sll0", 1'b0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      do_op("sra31", 1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);

      // Start while busy must be ignored.
      ctrl_start    = 1'b1;
      ctrl_shiftop  = 1'b0;
      ctrl_shiftamt = 5'd4;
      data_operandA = 32'h0000_00FF;
      step();
      ctrl_start = 1'b0;
      step();
      step();
      ctrl_start    = 1'b1;
      ctrl_shiftop  = 1'b1;
      ctrl_shiftamt = 5'd8;
      data_operandA = 32'hFFFF_FFFF;
      step();
      ctrl_start = 1'b0;
      step();
      step();
      check_eq("ovl_rdy", 32'(data_resultRDY), 32'd1);
      check_eq("ovl_result", data_result, 32'h0000_0FF0);
      for (int c = 0; c < 8; c++) begin
         step();
         check_eq("ovl_no_rdy", 32'(data_resultRDY), 32'd0);
         check_eq("ovl_idle", 32'(busy), 32'd0);
      end

      // Back-to-back: start held high, second op accepted in DONE.
      ctrl_start    = 1'b1;
      ctrl_shiftop  = 1'b0;
      ctrl_shiftamt = 5'd1;
      data_operandA = 32'h1;
      step();
      for (int c = 1; c <= 5; c++) begin
         check_eq("b2b_rdy0", 32'(data_resultRDY), 32'd0);
         step();
      end
      check_eq("b2b_rdy1", 32'(data_resultRDY), 32'd1);
      check_eq("b2b_res1", data_result, 32'h2);
      ctrl_shiftamt = 5'd2;
      step();
      check_eq("b2b_busy2", 32'(busy), 32'd1);
      check_eq("b2b_pulse1", 32'(data_resultRDY), 32'd0);
      ctrl_start = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         step();
         check_eq("b2b_hold", data_result, 32'h2);
         check_eq("b2b_rdy_mid", 32'(data_resultRDY), 32'd0);
      end
      step();
      check_eq("b2b_rdy2", 32'(data_resultRDY), 32'd1);
      check_eq("b2b_res2", data_result, 32'h4);
      step();
      check_eq("b2b_pulse2", 32'(data_resultRDY), 32'd0);
      check_eq("b2b_idle", 32'(busy), 32'd0);

      // Reset mid-SHIFT aborts the op.
      ctrl_start    = 1'b1;
      ctrl_shiftop  = 1'b1;
      ctrl_shiftamt = 5'd3;
      data_operandA = 32'h8000_0001;
      step();
      ctrl_start = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("abort_result", data_result, 32'h0);
      check_eq("abort_rdy", 32'(data_resultRDY), 32'd0);
      check_eq("abort_busy", 32'(busy), 32'd0);
      for (int c = 0; c < 6; c++) begin
         step();
         check_eq("abort_no_rdy", 32'(data_resultRDY), 32'd0);
      end
      do_op("sll30", 1'b0, 5'd30, 32'h0000_0003, 32'hC000_0000);

      // Reset and start together: start dropped.
      reset      = 1'b1;
      ctrl_start = 1'b1;
      step();
      reset      = 1'b0;
      ctrl_start = 1'b0;
      check_eq("rststart_busy", 32'(busy), 32'd0);
      step();
      check_eq("rststart_busy2", 32'(busy), 32'd0);
      for (int c = 0; c < 6; c++) step();
      check_eq("rststart_no_rdy", 32'(data_resultRDY), 32'd0);
      check_eq("rststart_result", data_result, 32'h0);

      // Sweep every amount for both ops against the reference model.
      for (int amt = 0; amt < 32; amt++) begin
         for (int op = 0; op < 2; op++) begin
            logic [31:0] a;
            a     = $urandom;
            a[31] = amt[0] ^ op[0];
            do_op("sweep", op[0], amt[4:0], a, ref_shift(op[0], amt[4:0], a));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_iter_unit.md
Name: shift_iter_unit

Overview:
- Multi-cycle 32-bit shifter for the ALU's shift path.
- Primary op is logical left shift (SLL); arithmetic right shift (SRA) is also selectable.
- Shift amount is decomposed into power-of-two stages (16/8/4/2/1), one stage per clock. This replaces a wide combinational barrel shifter.
- Sits beside the ALU and is driven by the multdiv-style start/ready handshake.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width. Number of stages = SHAMT_W; stage k shifts by 2^k. DATA_W must equal 2^SHAMT_W.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ctrl_start  input  1  request; sampled every cycle, accepted only when not busy.
- ctrl_shiftop  input  1  0 = SLL (zero fill), 1 = SRA (sign fill from operand MSB).
- ctrl_shiftamt  input  SHAMT_W  shift amount, unsigned, 0..DATA_W-1.
- data_operandA  input  DATA_W  value to shift.
- data_result  output  DATA_W  shifted value; valid when data_resultRDY=1, held until the next accept.
- data_resultRDY  output  1  one-cycle pulse, result valid.
- busy  output  1  high from the cycle after accept through the last stage cycle.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; data_result=0; data_resultRDY=0; busy=0.
  - Internal operand/amount/op/stage-counter registers cleared.
- State IDLE:
  - ctrl_start=1 is an accept. On the accept edge, latch data_operandA, ctrl_shiftamt and ctrl_shiftop into internal registers. Stage index = SHAMT_W-1. Go to SHIFT. busy=1 next cycle.
- State SHIFT, one stage per cycle, MSB stage first (16, 8, 4, 2, 1):
  - If the latched amount bit[k]=1: SLL uses reg = reg << 2^k (zero fill); SRA uses reg = reg >>> 2^k (replicate the latched operand's bit DATA_W-1).
  - If bit[k]=0: reg unchanged.
  - Stage index decrements each cycle.
  - After the stage-0 edge: go to DONE, with data_result = final reg.
- State DONE (one cycle):
  - data_resultRDY=1, busy=0. Next edge returns to IDLE.
  - ctrl_start=1 in DONE is a valid accept. The next operation begins with the same latching as in IDLE, and RDY falls next cycle.
- Latency:
  - Accept at edge N gives SHIFT stages on edges N+1..N+SHAMT_W.
  - data_resultRDY is high during the cycle after edge N+SHAMT_W (5-cycle latency for the default).
  - Throughput: one op per SHAMT_W+1 cycles.
- Boundary conditions:
  - ctrl_start while busy=1 is ignored. No queuing, no effect on the in-flight op.
  - Input changes after accept have no effect; only latched values are used.
  - shamt=0 gives result = operand, still full latency.
  - shamt=DATA_W-1: SLL leaves only bit0 moved to the MSB; SRA yields all-sign.
  - data_result keeps its last value through IDLE. It updates only at DONE entry and clears only on reset.
  - Reset mid-SHIFT aborts the op: no RDY pulse, result=0.
  - Reset and start in the same cycle: reset wins and the start is dropped.
- Arithmetic: purely bit movement. There is no overflow flag; bits shifted out are discarded.

Test Plan:
- Reset, then SLL 0x0000_0001 by 31 with start for 1 cycle → busy high 5 cycles, RDY pulses exactly 1 cycle at the 6th cycle after the accept edge, data_result=0x8000_0000.
- SRA 0x8000_0000 by 16 → 0xFFFF_8000. SRA 0x7FFF_0000 by 16 → 0x0000_7FFF. SLL 0x1234_5678 by 16 → 0x5678_0000. SLL 0xDEAD_BEEF by 0 → 0xDEAD_BEEF, same latency.
- Start SLL 0x0000_00FF by 4. Two cycles later assert start with SRA 0xFFFF_FFFF by 8, and change operand/amount. Second start ignored, single RDY, data_result=0x0000_0FF0.
- Back-to-back: hold ctrl_start=1 continuously with SLL 0x1 by 1, then SLL 0x1 by 2 presented at DONE. Two RDY pulses 6 cycles apart with results 0x2 and 0x4; data_result holds 0x2 between pulses.
- Start SRA 0x8000_0001 by 3. Assert reset on the 3rd SHIFT cycle → outputs 0/0/0 next edge, no RDY. Then a new SLL 0x3 by 30 → 0xC000_0000.
- Randomized sweep: compare against a reference model for all shamt 0..31 × both ops × random operands, checking latency and that RDY is a single-cycle pulse each time.
